// File: rtl/holo_lsu.sv
// rtl/holo_lsu.sv - byte-serial RV32I load/store unit for an 8-bit data memory
// Splits B/H/W accesses into little-endian byte transfers with alignment, funct3 and wait-timeout checks.
module holo_lsu #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  localparam int WCW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WCW:0] WLIM = (WCW + 1)'(WAIT_LIMIT);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_F3    = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

  state_t          state_q, state_d;
  logic            st_q;
  logic [2:0]      f3_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [1:0]      last_q;
  logic [1:0]      idx_q;
  logic [1:0]      nxt_idx;
  logic [WCW-1:0]  wcnt_q;
  logic [WCW:0]    wcnt_inc;
  logic [31:0]     buf_q;
  logic [1:0]      err_p;
  logic            illegal;
  logic            misal;
  logic [1:0]      last_in;
  logic            byte_done;
  logic            tmo;
  logic [31:0]     ext;

  // Request decode on the raw inputs; only meaningful in IDLE with start high.
  always_comb begin
    illegal = (funct3 == 3'b011) || (funct3[2] && funct3[1]) || (funct3[2] && is_store);
    misal   = ((funct3[1:0] == 2'b01) && addr[0]) ||
              ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b01:   last_in = 2'd1;
      2'b10:   last_in = 2'd3;
      default: last_in = 2'd0;
    endcase
  end

  assign nxt_idx  = idx_q + 2'd1;
  assign wcnt_inc = {1'b0, wcnt_q} + {{WCW{1'b0}}, 1'b1};

  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{buf_q[7]}}, buf_q[7:0]};
      3'b001:  ext = {{16{buf_q[15]}}, buf_q[15:0]};
      3'b100:  ext = {24'd0, buf_q[7:0]};
      3'b101:  ext = {16'd0, buf_q[15:0]};
      default: ext = buf_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    byte_done = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (illegal || misal) ? FIN : XFER;
      end
      XFER: begin
        if (mem_ready) begin
          byte_done = 1'b1;
          if (idx_q == last_q) state_d = FIN;
        end else if ((WAIT_LIMIT != 0) && (wcnt_inc == WLIM)) begin
          tmo     = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      last_q    <= 2'd0;
      idx_q     <= 2'd0;
      wcnt_q    <= '0;
      buf_q     <= 32'd0;
      err_p     <= ERR_OK;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= ERR_OK;
      rdata     <= 32'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 8'd0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            st_q    <= is_store;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            last_q  <= last_in;
            idx_q   <= 2'd0;
            wcnt_q  <= '0;
            busy    <= 1'b1;
            if (illegal) begin
              err_p <= ERR_F3;
            end else if (misal) begin
              err_p <= ERR_ALIGN;
            end else begin
              err_p     <= ERR_OK;
              mem_addr  <= addr;
              mem_wdata <= wdata[7:0];
              mem_we    <= is_store;
              mem_re    <= !is_store;
            end
          end
        end
        XFER: begin
          if (byte_done) begin
            if (!st_q) buf_q[8*idx_q +: 8] <= mem_rdata;
            wcnt_q <= '0;
            if (idx_q == last_q) begin
              mem_we <= 1'b0;
              mem_re <= 1'b0;
            end else begin
              idx_q     <= nxt_idx;
              mem_addr  <= addr_q + {30'd0, nxt_idx};
              mem_wdata <= 8'(wdata_q >> {nxt_idx, 3'b000});
            end
          end else if (tmo) begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            err_p  <= ERR_TMO;
          end else begin
            wcnt_q <= wcnt_q + {{(WCW-1){1'b0}}, 1'b1};
          end
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
          err  <= err_p;
          // Buffer is complete here: the last byte landed on the edge that entered FIN.
          if (!st_q && (err_p == ERR_OK)) rdata <= ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_holo_lsu.sv
// tb/tb_holo_lsu.sv - directed scoreboard bench for holo_lsu
// Expected byte transfers and completions are queued when a request is driven and checked as the DUT produces them.
module tb_holo_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done;
  logic [1:0]  err;
  logic [31:0] rdata, mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_ready = 1'b1;

  logic [7:0]  mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];

  holo_lsu #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    logic        we;
  } byte_t;

  typedef struct {
    logic [1:0]  e;
    logic [31:0] r;
    int          cyc;
  } res_t;

  byte_t bq[$];
  res_t  rq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request from the current negedge and follow it to done.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int nb, input int stall_in,
                        input logic [1:0] e_err, input logic [31:0] e_rd,
                        input int e_cyc, input int left);
    byte_t b;
    res_t  r;
    byte_t h;
    int    cyc;
    int    stall;
    bit    got;
    for (int i = 0; i < nb; i++) begin
      b.a  = a + i;
      b.d  = 8'(wd >> (8 * i));
      b.we = st;
      bq.push_back(b);
    end
    r.e = e_err; r.r = e_rd; r.cyc = e_cyc;
    rq.push_back(r);
    is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    cyc = 0; got = 1'b0; stall = stall_in;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk("busy_after_start", {31'd0, busy}, 32'd1);
      if (mem_re || mem_we) begin
        if (bq.size() == 0) begin
          chk("strobe_with_no_transfer_due", {31'd0, mem_re | mem_we}, 32'd0);
        end else begin
          h = bq[0];
          chk("byte_addr", mem_addr, h.a);
          chk("byte_we", {31'd0, mem_we}, {31'd0, h.we});
          chk("byte_re", {31'd0, mem_re}, {31'd0, !h.we});
          if (h.we) chk("byte_wdata", {24'd0, mem_wdata}, {24'd0, h.d});
          if (stall > 0) begin
            stall--;
            mem_ready = 1'b0;
          end else begin
            mem_ready = 1'b1;
            void'(bq.pop_front());
          end
        end
      end else begin
        mem_ready = 1'b1;
      end
      if (done) begin
        got = 1'b1;
        r = rq.pop_front();
        chk("done_err", {30'd0, err}, {30'd0, r.e});
        chk("done_rdata", rdata, r.r);
        chk("done_cycle", cyc, r.cyc);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("strobes_at_done", {30'd0, mem_we, mem_re}, 32'd0);
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    if (!got) void'(rq.pop_front());
    chk("bytes_left", bq.size(), left);
    bq.delete();
    mem_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[6] = 8'h34; mem[7] = 8'h80;

    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {30'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b0, 3'b010, 32'h0000_0100, 32'd0, 4, 0, 2'b00, 32'h4433_2211, 6, 0);
    do_req(1'b0, 3'b000, 32'h0000_0007, 32'd0, 1, 0, 2'b00, 32'hFFFF_FF80, 3, 0);
    do_req(1'b0, 3'b100, 32'h0000_0007, 32'd0, 1, 0, 2'b00, 32'h0000_0080, 3, 0);
    do_req(1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 2, 3, 2'b00, 32'h0000_0080, 7, 0);
    do_req(1'b0, 3'b010, 32'h0000_0102, 32'd0, 0, 0, 2'b01, 32'h0000_0080, 2, 0);
    do_req(1'b1, 3'b100, 32'h0000_0040, 32'h1234_5678, 0, 0, 2'b10, 32'h0000_0080, 2, 0);
    do_req(1'b0, 3'b011, 32'h0000_0040, 32'd0, 0, 0, 2'b10, 32'h0000_0080, 2, 0);
    do_req(1'b0, 3'b101, 32'h0000_0005, 32'd0, 0, 0, 2'b01, 32'h0000_0080, 2, 0);
    do_req(1'b0, 3'b001, 32'h0000_0006, 32'd0, 2, 0, 2'b00, 32'hFFFF_8034, 4, 0);
    do_req(1'b0, 3'b101, 32'h0000_0006, 32'd0, 2, 0, 2'b00, 32'h0000_8034, 4, 0);
    do_req(1'b0, 3'b000, 32'hFFFF_FFFF, 32'd0, 1, 1000, 2'b11, 32'h0000_8034, 18, 1);

    // Abandon a word load while its third byte is on the bus.
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_addr", mem_addr, 32'h0000_0102);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_in_reset", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    do_req(1'b0, 3'b000, 32'h0000_0007, 32'd0, 1, 0, 2'b00, 32'hFFFF_FF80, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
